// File: rtl/sprite_drawer.sv
// sprite_drawer: sprite draw engine feeding the SRAM frame-buffer controller.
//
// A rising edge on frame_clk starts a pass over MAX_SPRITES descriptor
// slots. For each live sprite, its pixels are fetched row-major from the
// sprite ROM. Transparent and off-screen pixels are skipped, and every
// visible pixel is presented on program_x/program_y/program_data. Each
// pixel takes exactly two cycles, so the controller's program-write slot
// (one every two cycles) always captures it.
//
// Ports:
//   sram_clk      clock shared with the SRAM controller
//   reset         synchronous, active-high
//   frame_clk     frame toggle; its rising edge starts a draw pass
//   desc_index    descriptor slot being requested
//   desc_valid    slot holds a live sprite (1 cycle after desc_index)
//   desc_x/y      sprite top-left corner
//   desc_w/h      sprite size in pixels; 0 means skip
//   desc_base     ROM address of the sprite's first pixel
//   rom_addr      sprite ROM address (registered)
//   rom_data      ROM pixel, valid 1 cycle after rom_addr
//   program_x/y   pixel coordinate to the SRAM controller
//   program_data  pixel colour to the SRAM controller
//   busy          draw pass in progress
//   overrun       sticky: a frame edge arrived while busy
module sprite_drawer #(
  parameter int          MAX_SPRITES = 32,
  parameter int          ROM_AW      = 16,
  parameter logic [15:0] TRANSPARENT = 16'hF81F,
  parameter int          SCREEN_W    = 640,
  parameter int          SCREEN_H    = 480
) (
  input  logic                           sram_clk,
  input  logic                           reset,
  input  logic                           frame_clk,
  output logic [$clog2(MAX_SPRITES)-1:0] desc_index,
  input  logic                           desc_valid,
  input  logic [9:0]                     desc_x,
  input  logic [9:0]                     desc_y,
  input  logic [5:0]                     desc_w,
  input  logic [5:0]                     desc_h,
  input  logic [ROM_AW-1:0]              desc_base,
  output logic [ROM_AW-1:0]              rom_addr,
  input  logic [15:0]                    rom_data,
  output logic [9:0]                     program_x,
  output logic [9:0]                     program_y,
  output logic [15:0]                    program_data,
  output logic                           busy,
  output logic                           overrun
);

  localparam int IW = $clog2(MAX_SPRITES);
  localparam logic [IW-1:0] LAST_IDX = IW'(MAX_SPRITES - 1);
  localparam logic [10:0]   SW       = 11'(SCREEN_W);
  localparam logic [10:0]   SH       = 11'(SCREEN_H);

  typedef enum logic [2:0] {
    IDLE,
    DESC_REQ,
    DESC_LATCH,
    PIX_ADDR,
    PIX_DATA
  } state_t;

  state_t      state;
  logic        frame_q;
  logic        frame_q2;
  logic        start;
  logic [9:0]  x_r;
  logic [9:0]  y_r;
  logic [5:0]  w_r;
  logic [5:0]  h_r;
  logic [5:0]  col;
  logic [5:0]  row;

  // 11-bit sums so sprites hanging off the right/bottom edge never wrap
  // back onto the screen.
  logic [10:0] px;
  logic [10:0] py;
  logic        visible;
  logic        last_col;
  logic        last_row;
  logic        last_slot;

  always_comb begin
    px        = {1'b0, x_r} + {5'd0, col};
    py        = {1'b0, y_r} + {5'd0, row};
    visible   = (rom_data != TRANSPARENT) && (px < SW) && (py < SH);
    last_col  = (col == w_r - 6'd1);
    last_row  = (row == h_r - 6'd1);
    last_slot = (desc_index == LAST_IDX);
  end

  always_ff @(posedge sram_clk) begin
    if (reset) begin
      state        <= IDLE;
      frame_q      <= 1'b0;
      frame_q2     <= 1'b0;
      start        <= 1'b0;
      desc_index   <= '0;
      rom_addr     <= '0;
      program_x    <= '0;
      program_y    <= '0;
      program_data <= '0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      x_r          <= '0;
      y_r          <= '0;
      w_r          <= '0;
      h_r          <= '0;
      col          <= '0;
      row          <= '0;
    end else begin
      frame_q  <= frame_clk;
      frame_q2 <= frame_q;
      start    <= frame_q & ~frame_q2;

      // A frame edge during a pass (including its final cycle) wins over
      // whatever the FSM would otherwise do: flag it and restart at slot 0.
      if (start && busy) begin
        overrun    <= 1'b1;
        desc_index <= '0;
        state      <= DESC_REQ;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              busy       <= 1'b1;
              desc_index <= '0;
              state      <= DESC_REQ;
            end
          end

          DESC_REQ: state <= DESC_LATCH;

          DESC_LATCH: begin
            x_r <= desc_x;
            y_r <= desc_y;
            w_r <= desc_w;
            h_r <= desc_h;
            if (!desc_valid || desc_w == 6'd0 || desc_h == 6'd0) begin
              if (last_slot) begin
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                desc_index <= desc_index + 1'b1;
                state      <= DESC_REQ;
              end
            end else begin
              col      <= '0;
              row      <= '0;
              rom_addr <= desc_base;
              state    <= PIX_ADDR;
            end
          end

          PIX_ADDR: state <= PIX_DATA;

          PIX_DATA: begin
            if (visible) begin
              program_x    <= px[9:0];
              program_y    <= py[9:0];
              program_data <= rom_data;
            end
            // Row-major with stride w, so a running pointer replaces y*w+x.
            rom_addr <= rom_addr + 1'b1;
            if (last_col) begin
              col <= '0;
              row <= row + 6'd1;
            end else begin
              col <= col + 6'd1;
            end
            if (last_col && last_row) begin
              if (last_slot) begin
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                desc_index <= desc_index + 1'b1;
                state      <= DESC_REQ;
              end
            end else begin
              state <= PIX_ADDR;
            end
          end

          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprite_drawer.sv
module tb_sprite_drawer;

  logic        sram_clk;
  logic        reset;
  logic        frame_clk;
  logic [4:0]  desc_index;
  logic        desc_valid;
  logic [9:0]  desc_x;
  logic [9:0]  desc_y;
  logic [5:0]  desc_w;
  logic [5:0]  desc_h;
  logic [15:0] desc_base;
  logic [15:0] rom_addr;
  logic [15:0] rom_data;
  logic [9:0]  program_x;
  logic [9:0]  program_y;
  logic [15:0] program_data;
  logic        busy;
  logic        overrun;

  sprite_drawer #(
    .MAX_SPRITES(32),
    .ROM_AW(16),
    .TRANSPARENT(16'hF81F),
    .SCREEN_W(640),
    .SCREEN_H(480)
  ) dut (
    .sram_clk(sram_clk),
    .reset(reset),
    .frame_clk(frame_clk),
    .desc_index(desc_index),
    .desc_valid(desc_valid),
    .desc_x(desc_x),
    .desc_y(desc_y),
    .desc_w(desc_w),
    .desc_h(desc_h),
    .desc_base(desc_base),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .program_x(program_x),
    .program_y(program_y),
    .program_data(program_data),
    .busy(busy),
    .overrun(overrun)
  );

  initial sram_clk = 1'b0;
  always #5 sram_clk = ~sram_clk;

  // Descriptor table and sprite ROM, both with one cycle of read latency.
  logic        dv [0:31];
  logic [9:0]  dx [0:31];
  logic [9:0]  dy [0:31];
  logic [5:0]  dw [0:31];
  logic [5:0]  dh [0:31];
  logic [15:0] db [0:31];
  logic [15:0] rom [0:65535];

  always @(posedge sram_clk) begin
    desc_valid <= dv[desc_index];
    desc_x     <= dx[desc_index];
    desc_y     <= dy[desc_index];
    desc_w     <= dw[desc_index];
    desc_h     <= dh[desc_index];
    desc_base  <= db[desc_index];
    rom_data   <= rom[rom_addr];
  end

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] d;
    int          gap;   // expected cycles since previous change; 0 = any
  } exp_t;

  exp_t sb[$];
  logic mon_en = 1'b0;

  // Monitor: every change on program_* is one presented pixel.
  logic [35:0] prev = '0;
  int cyc = 0;
  int last_chg = 0;
  always @(negedge sram_clk) begin
    exp_t e;
    cyc++;
    if ({program_x, program_y, program_data} !== prev) begin
      if (mon_en) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got (%0d,%0d,%h) required none",
                   program_x, program_y, program_data);
        end else begin
          e = sb.pop_front();
          if (program_x !== e.x || program_y !== e.y || program_data !== e.d) begin
            errors++;
            $display("FAIL pixel: got (%0d,%0d,%h) required (%0d,%0d,%h)",
                     program_x, program_y, program_data, e.x, e.y, e.d);
          end
          checks++;
          if (cyc - last_chg < 2) begin
            errors++;
            $display("FAIL min_hold: got %0d cycles required >=2", cyc - last_chg);
          end
          if (e.gap > 0) begin
            checks++;
            if (cyc - last_chg != e.gap) begin
              errors++;
              $display("FAIL hold_gap: got %0d cycles required %0d", cyc - last_chg, e.gap);
            end
          end
        end
      end
      prev     = {program_x, program_y, program_data};
      last_chg = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [9:0] x, input logic [9:0] y, input logic [15:0] d,
                      input int gap);
    exp_t e;
    e.x = x; e.y = y; e.d = d; e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic clear_desc();
    for (int i = 0; i < 32; i++) begin
      dv[i] = 1'b0; dx[i] = '0; dy[i] = '0; dw[i] = '0; dh[i] = '0; db[i] = '0;
    end
  endtask

  task automatic set_desc(input int slot, input logic [9:0] x, input logic [9:0] y,
                          input logic [5:0] w, input logic [5:0] h, input logic [15:0] base);
    dv[slot] = 1'b1; dx[slot] = x; dy[slot] = y; dw[slot] = w; dh[slot] = h; db[slot] = base;
  endtask

  // Raise frame_clk, measure how long busy stays high, then drop frame_clk.
  task automatic run_pass(input string name, input int exp_busy);
    int n;
    int cnt;
    @(negedge sram_clk);
    frame_clk = 1'b1;
    n = 0;
    while (!busy && n < 10) begin
      @(negedge sram_clk);
      n++;
    end
    if (!busy) begin
      chk({name, "_busy_start_timeout"}, 32'(busy), 32'd1);
    end else begin
      cnt = 0;
      while (busy && cnt < 20000) begin
        cnt++;
        @(negedge sram_clk);
      end
      chk({name, "_busy_cycles"}, 32'(cnt), 32'(exp_busy));
    end
    frame_clk = 1'b0;
    repeat (4) @(negedge sram_clk);
    chk({name, "_queue_empty"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic check_zero(input string name);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_overrun"}, 32'(overrun), 32'd0);
    chk({name, "_desc_index"}, 32'(desc_index), 32'd0);
    chk({name, "_rom_addr"}, 32'(rom_addr), 32'd0);
    chk({name, "_program_x"}, 32'(program_x), 32'd0);
    chk({name, "_program_y"}, 32'(program_y), 32'd0);
    chk({name, "_program_data"}, 32'(program_data), 32'd0);
  endtask

  logic [9:0]  save_x;
  logic [9:0]  save_y;
  logic [15:0] save_d;
  logic [15:0] save_a;

  initial begin
    reset     = 1'b1;
    frame_clk = 1'b0;
    for (int i = 0; i < 65536; i++) rom[i] = 16'h0000;
    clear_desc();
    repeat (4) @(negedge sram_clk);
    check_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge sram_clk);
    mon_en = 1'b1;

    // 2x2 sprite at (10,20)
    set_desc(0, 10'd10, 10'd20, 6'd2, 6'd2, 16'h0100);
    rom[16'h0100] = 16'h1111; rom[16'h0101] = 16'h2222;
    rom[16'h0102] = 16'h3333; rom[16'h0103] = 16'h4444;
    push(10'd10, 10'd20, 16'h1111, 0);
    push(10'd11, 10'd20, 16'h2222, 2);
    push(10'd10, 10'd21, 16'h3333, 2);
    push(10'd11, 10'd21, 16'h4444, 2);
    run_pass("basic", 72);

    // Transparent second pixel: previous output held for 4 cycles
    rom[16'h0101] = 16'hF81F;
    push(10'd10, 10'd20, 16'h1111, 0);
    push(10'd10, 10'd21, 16'h3333, 4);
    push(10'd11, 10'd21, 16'h4444, 2);
    run_pass("transparent", 72);

    // Right-edge and bottom-edge clipping
    clear_desc();
    set_desc(0, 10'd639, 10'd100, 6'd2, 6'd1, 16'h0020);
    set_desc(1, 10'd5, 10'd479, 6'd1, 6'd2, 16'h0030);
    rom[16'h0020] = 16'hAAAA; rom[16'h0021] = 16'hBBBB;
    rom[16'h0030] = 16'hCCCC; rom[16'h0031] = 16'hDDDD;
    push(10'd639, 10'd100, 16'hAAAA, 0);
    push(10'd5, 10'd479, 16'hCCCC, 6);
    run_pass("clip", 72);

    // All slots invalid
    clear_desc();
    save_x = program_x; save_y = program_y; save_d = program_data; save_a = rom_addr;
    run_pass("empty", 64);
    chk("empty_program_x", 32'(program_x), 32'(save_x));
    chk("empty_program_y", 32'(program_y), 32'(save_y));
    chk("empty_program_data", 32'(program_data), 32'(save_d));
    chk("empty_rom_addr", 32'(rom_addr), 32'(save_a));

    // Overrun: 63x63 sprite, frame_clk toggling every 1000 cycles
    mon_en = 1'b0;
    set_desc(0, 10'd0, 10'd0, 6'd63, 6'd63, 16'h1000);
    for (int i = 0; i < 3969; i++) rom[16'h1000 + i] = 16'(i + 1);
    @(negedge sram_clk);
    frame_clk = 1'b1;
    repeat (1000) @(negedge sram_clk);
    chk("ovr_busy_before", 32'(busy), 32'd1);
    chk("ovr_flag_before", 32'(overrun), 32'd0);
    frame_clk = 1'b0;
    repeat (1000) @(negedge sram_clk);
    frame_clk = 1'b1;
    repeat (3) @(negedge sram_clk);
    chk("ovr_flag_after", 32'(overrun), 32'd1);
    chk("ovr_busy_after", 32'(busy), 32'd1);
    chk("ovr_desc_index", 32'(desc_index), 32'd0);
    repeat (2) @(negedge sram_clk);
    chk("ovr_restart_rom_addr", 32'(rom_addr), 32'h1000);

    // Reset mid-pixel
    repeat (7) @(negedge sram_clk);
    reset = 1'b1;
    @(negedge sram_clk);
    check_zero("midreset");
    reset     = 1'b0;
    frame_clk = 1'b0;
    repeat (3) @(negedge sram_clk);

    // Drawing resumes normally after reset
    clear_desc();
    set_desc(0, 10'd10, 10'd20, 6'd2, 6'd2, 16'h0100);
    rom[16'h0101] = 16'h2222;
    mon_en = 1'b1;
    push(10'd10, 10'd20, 16'h1111, 0);
    push(10'd11, 10'd20, 16'h2222, 2);
    push(10'd10, 10'd21, 16'h3333, 2);
    push(10'd11, 10'd21, 16'h4444, 2);
    run_pass("after_reset", 72);
    chk("after_reset_overrun", 32'(overrun), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_drawer.md
Name: sprite_drawer

Overview:
Draw engine that sits directly upstream of the SRAM frame-buffer controller and drives its program_x / program_y / program_data inputs. On each frame_clk rising edge it walks a sprite descriptor list and reads each sprite's pixels from a sprite ROM. It skips transparent and off-screen pixels and presents every visible pixel, stable for at least 2 sram_clk cycles, so that one of the controller's program-write slots (one every 2 cycles) captures it into the hidden frame.

Parameters:
MAX_SPRITES, 32, number of descriptor slots walked per frame (power of 2)
ROM_AW, 16, sprite ROM address width
TRANSPARENT, 16'hF81F, colour key that is never written
SCREEN_W, 640, visible width; pixels with x >= SCREEN_W are clipped
SCREEN_H, 480, visible height; pixels with y >= SCREEN_H are clipped

Ports:
sram_clk  in  1  100 MHz clock, same as the SRAM controller
reset  in  1  synchronous, active-high
frame_clk  in  1  frame toggle; the rising edge starts a draw pass
desc_index  out  $clog2(MAX_SPRITES)  descriptor slot being requested
desc_valid  in  1  slot holds a live sprite; valid 1 cycle after desc_index
desc_x  in  10  sprite left column
desc_y  in  10  sprite top row
desc_w  in  6  width in pixels; 0 means skip
desc_h  in  6  height in pixels; 0 means skip
desc_base  in  ROM_AW  ROM address of the sprite's first pixel (row-major, stride desc_w)
rom_addr  out  ROM_AW  sprite ROM address (registered)
rom_data  in  16  ROM pixel, valid 1 cycle after rom_addr
program_x  out  10  pixel column to the SRAM controller
program_y  out  10  pixel row to the SRAM controller
program_data  out  16  pixel colour to the SRAM controller
busy  out  1  draw pass in progress
overrun  out  1  sticky: a frame edge arrived while busy

Behaviour:
- Reset: state IDLE; desc_index, rom_addr, program_x, program_y, program_data, busy and overrun all 0; edge detector cleared. Reset mid-pass abandons the pass immediately.
- Frame edge: frame_clk is registered once, then rising edge = frame_clk & ~delayed, registered. This gives a 1-cycle start pulse 2 cycles after the frame_clk rise.
- States: IDLE, DESC_REQ, DESC_LATCH, PIX_ADDR, PIX_DATA.
- IDLE: on the start pulse, set busy=1, desc_index=0, and go to DESC_REQ.
- DESC_REQ (1 cycle): desc_index is stable. Go to DESC_LATCH.
- DESC_LATCH (1 cycle): latch x, y, w, h and base.
  - If !desc_valid, w==0 or h==0, advance to the next index (DESC_REQ).
  - Otherwise set col=0, row=0, rom_addr=desc_base, and go to PIX_ADDR.
- PIX_ADDR (1 cycle): the ROM samples rom_addr. Go to PIX_DATA.
- PIX_DATA (1 cycle): compute px = x+col and py = y+row at 11-bit width (no wrap).
  - If rom_data != TRANSPARENT, px < SCREEN_W and py < SCREEN_H, load program_x/y/data from px[9:0], py[9:0], rom_data. Otherwise hold the program_* outputs.
  - Increment rom_addr (running pointer; no multiplier).
  - Advance col. When col==w-1, set col=0 and row++.
  - Go to PIX_ADDR; after the last pixel (col==w-1, row==h-1), advance the index.
- Advance index: if the index is MAX_SPRITES-1, go to IDLE with busy=0. Otherwise index++ and go to DESC_REQ.
- Timing: each pixel takes exactly 2 cycles, so program_* never changes more often than every 2 cycles. Re-writing a held pixel is idempotent, so while idle or skipping, the held value is rewritten harmlessly.
- Pass length: 2·MAX_SPRITES + Σ(2·w·h) cycles over drawn sprites.
- Frame edge while busy: set overrun=1 (cleared only by reset), abandon the current pass, and restart at index 0 (DESC_REQ) next cycle; busy stays 1.
- Frame edge in the same cycle as pass completion: the edge wins; restart and set overrun.

Test Plan:
- Single 2x2 sprite in slot 0 at (10,20), ROM words 0x1111, 0x2222, 0x3333, 0x4444, other slots invalid → program outputs (10,20,1111), (11,20,2222), (10,21,3333), (11,21,4444), each held exactly 2 cycles. busy high for 2·32 + 8 = 72 cycles.
- Same sprite with ROM word 1 = 0xF81F → after (10,20,1111), outputs hold for 4 cycles, then (10,21,3333).
- Sprite at x=639, w=2, h=1 → only (639,y) is written; the col-1 pixel is clipped and outputs hold. y=479, h=2 → row 1 is clipped.
- All slots invalid → busy high for exactly 64 cycles; program_* unchanged; rom_addr unchanged.
- 63x63 sprite (about 7.9k cycles) with frame_clk toggling every 1000 cycles → overrun=1 after the second edge; desc_index returns to 0 and the pass restarts.
- Reset asserted mid-pixel → next cycle state IDLE, all outputs 0. A new frame edge then restarts drawing normally.
